adder6b: RTL and testbench

ADDER6B -- requirements
Module: adder6b

---
 rtl/adder6b.sv | 88 ++++++++
 tb/tb_adder6b.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/adder6b.sv
// 6-bit ripple-carry adder with a combinational sum/carry path and a one-cycle registered result.
// Optional registered overflow/zero flags are enabled by defining ADDER6B_FLAGS_EN.
module adder6b #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic             in_valid,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             zero_q
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  // Explicit full-adder chain, so an X on one operand bit only disturbs the bits above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             out_valid_d;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d  = sum;
      cout_d = cout;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      out_valid <= out_valid_d;
    end
  end

`ifdef ADDER6B_FLAGS_EN
  logic ovf_d;
  logic zero_d;

  // Signed overflow: operands share a sign and the result's sign differs from it.
  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (in_valid) begin
      ovf_d  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      zero_d = (sum == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end
`else
  assign ovf_q  = 1'b0;
  assign zero_q = 1'b0;
`endif

endmodule

// File: tb/tb_adder6b.sv
// Self-checking bench for adder6b: directed vectors feed a scoreboard queue, a monitor pops on out_valid.
// Flag expectations follow ADDER6B_FLAGS_EN as seen by the bench build.
module tb_adder6b;

`ifdef ADDER6B_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct {
    logic [5:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] a = '0;
  logic [5:0] b = '0;
  logic       in_valid = 1'b0;
  logic [5:0] sum, sum_q;
  logic       cout, out_valid, cout_q, ovf_q, zero_q;

  bit   clk_run = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  adder6b #(.WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sum(sum), .cout(cout),
    .in_valid(in_valid), .out_valid(out_valid), .sum_q(sum_q),
    .cout_q(cout_q), .ovf_q(ovf_q), .zero_q(zero_q)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum_q",  32'(sum_q),  32'(e.sum));
        check("cout_q", 32'(cout_q), 32'(e.cout));
        check("ovf_q",  32'(ovf_q),  32'(e.ovf));
        check("zero_q", 32'(zero_q), 32'(e.zero));
      end
    end
  end

  // Drive one valid vector on a falling edge; expected values are hand-computed by the caller.
  task automatic issue(input logic [5:0] av, input logic [5:0] bv, input logic [5:0] s,
                       input logic c, input logic o, input logic z);
    exp_t e;
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    e.sum  = s;
    e.cout = c;
    e.ovf  = FLAGS ? o : 1'b0;
    e.zero = FLAGS ? z : 1'b0;
    sb.push_back(e);
    #1;
    check("comb_sum",  32'(sum),  32'(s));
    check("comb_cout", 32'(cout), 32'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    logic [5:0] ra, rb;

    // Combinational path with clock idle and reset held.
    a = 6'h15; b = 6'h0A;
    #10;
    check("idle_sum",  32'(sum),  32'h1F);
    check("idle_cout", 32'(cout), 32'h0);
    check("rst_sum_q",     32'(sum_q),     32'h0);
    check("rst_cout_q",    32'(cout_q),    32'h0);
    check("rst_ovf_q",     32'(ovf_q),     32'h0);
    check("rst_zero_q",    32'(zero_q),    32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);

    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_valid", 32'(out_valid), 32'h0);

    // Back-to-back directed vectors: a, b, sum, cout, ovf, zero.
    issue(6'h3F, 6'h01, 6'h00, 1'b1, 1'b0, 1'b1);
    issue(6'h1F, 6'h01, 6'h20, 1'b0, 1'b1, 1'b0);
    issue(6'h20, 6'h20, 6'h00, 1'b1, 1'b1, 1'b1);
    issue(6'h15, 6'h0A, 6'h1F, 1'b0, 1'b0, 1'b0);
    issue(6'h3F, 6'h3F, 6'h3E, 1'b1, 1'b0, 1'b0);
    issue(6'h10, 6'h10, 6'h20, 1'b0, 1'b1, 1'b0);
    issue(6'h2A, 6'h15, 6'h3F, 1'b0, 1'b0, 1'b0);
    issue(6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1);
    issue(6'h30, 6'h28, 6'h18, 1'b1, 1'b1, 1'b0);

    // Hold: capture 3+4, then an idle edge with different operands.
    issue(6'h03, 6'h04, 6'h07, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    a = 6'h0A; b = 6'h0A;
    @(posedge clk); #1;
    check("hold_sum_q",     32'(sum_q),     32'h07);
    check("hold_out_valid", 32'(out_valid), 32'h0);
    check("hold_comb_sum",  32'(sum),       32'h14);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sum_q",     32'(sum_q),     32'h0);
    check("arst_cout_q",    32'(cout_q),    32'h0);
    check("arst_ovf_q",     32'(ovf_q),     32'h0);
    check("arst_zero_q",    32'(zero_q),    32'h0);
    check("arst_out_valid", 32'(out_valid), 32'h0);

    // In-flight vector discarded by reset; combinational path unaffected.
    @(negedge clk);
    rst_n = 1'b1;
    a = 6'h05; b = 6'h05; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("discard_out_valid", 32'(out_valid), 32'h0);
    check("discard_sum_q",     32'(sum_q),     32'h0);
    check("discard_comb_sum",  32'(sum),       32'h0A);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Random pairs at 10 ns spacing.
    for (int i = 0; i < 16; i++) begin
      ra = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      a = ra; b = rb;
      #10;
      check("rand_sum",  32'(sum),  32'(6'(ra + rb)));
      check("rand_cout", 32'(cout), 32'(7'({1'b0, ra} + {1'b0, rb}) >> 6));
    end

    // Exhaustive sweep of all operand pairs.
    bad = 0;
    for (int ia = 0; ia < 64; ia++) begin
      for (int ib = 0; ib < 64; ib++) begin
        a = 6'(ia); b = 6'(ib);
        #1;
        if ({cout, sum} !== 7'(ia + ib)) bad++;
      end
    end
    check("sweep_mismatches", 32'(bad), 32'd0);

    // A capture after the reset pulse still works and drains the scoreboard.
    issue(6'h01, 6'h02, 6'h03, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
